// File: rtl/ods_pkg.sv
// Default sizing for the output data shifter: word width, rows per column, column stages.
// Shared by ods_array and ods_col_stage so one edit retargets both.
package ods_pkg;

    localparam int ODS_IO_DATA_WIDTH = 16;
    localparam int ODS_NUM_ROWS      = 3;
    localparam int ODS_DEPTH         = 2;

endpackage

// File: rtl/ods_col_stage.sv
// One column register (NUM_ROWS words + valid); row writes override a whole-column load.
// Zero latency beyond the register; no flow control of its own, the parent decides load/clear.
module ods_col_stage
    import ods_pkg::*;
#(
    parameter int IO_DATA_WIDTH = ODS_IO_DATA_WIDTH,
    parameter int NUM_ROWS      = ODS_NUM_ROWS
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic                              load_en,
    input  logic [NUM_ROWS*IO_DATA_WIDTH-1:0] load_dat,
    input  logic [NUM_ROWS-1:0]               wr_en,
    input  logic [NUM_ROWS*IO_DATA_WIDTH-1:0] wr_dat,
    input  logic                              set_vld,
    input  logic                              clr,
    output logic [NUM_ROWS*IO_DATA_WIDTH-1:0] col_dat,
    output logic                              col_vld
);

    logic [NUM_ROWS*IO_DATA_WIDTH-1:0] dat_q, dat_d;
    logic                              vld_q, vld_d;

    // Clear then load then set: a stage emptied and refilled on one edge stays valid.
    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (clr) begin
            vld_d = 1'b0;
        end
        if (load_en) begin
            dat_d = load_dat;
            vld_d = 1'b1;
        end
        if (set_vld) begin
            vld_d = 1'b1;
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (wr_en[r]) begin
                dat_d[r*IO_DATA_WIDTH +: IO_DATA_WIDTH] = wr_dat[r*IO_DATA_WIDTH +: IO_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign col_dat = dat_q;
    assign col_vld = vld_q;

endmodule

// File: rtl/ods_array.sv
// Packs a word stream round-robin into NUM_ROWS-word columns and runs them through a DEPTH-stage elastic pipeline; ODS_ARRAY_FLUSH_EN adds flush_in.
// Column out DEPTH-1 cycles after its last word; in_ready drops only once stage 0 is complete and cannot advance.
module ods_array
    import ods_pkg::*;
#(
    parameter int IO_DATA_WIDTH = ODS_IO_DATA_WIDTH,
    parameter int NUM_ROWS      = ODS_NUM_ROWS,
    parameter int DEPTH         = ODS_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic [IO_DATA_WIDTH-1:0]          in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [NUM_ROWS*IO_DATA_WIDTH-1:0] out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
`ifdef ODS_ARRAY_FLUSH_EN
    input  logic                              flush_in,
`endif
    output logic [$clog2(DEPTH+1)-1:0]        col_count
);

    localparam int                COL_W   = NUM_ROWS * IO_DATA_WIDTH;
    localparam int                PTR_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(NUM_ROWS - 1);

    logic [DEPTH-1:0]    v;
    logic [DEPTH-1:0]    mv;
    logic [COL_W-1:0]    col_dat [DEPTH];
    logic [PTR_W-1:0]    ptr_q, ptr_d, ptr_adv;
    logic                st0_free;
    logic                accept;
    logic                complete;
    logic                flush_req;
    logic                flush_fire;
    logic [NUM_ROWS-1:0] st0_wr_en;
    logic [COL_W-1:0]    st0_wr_dat;
    logic [CNT_W-1:0]    cnt;

`ifdef ODS_ARRAY_FLUSH_EN
    assign flush_req = flush_in;
`else
    assign flush_req = 1'b0;
`endif

    // Walk from the output back: a stage may move if the next one is empty or moving too.
    always_comb begin
        logic take;
        take = out_ready;
        mv   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            mv[k] = v[k] & take;
            take  = !v[k] | mv[k];
        end
        st0_free = take;
    end

    assign in_ready = !rst_in & st0_free;
    assign accept   = in_valid & in_ready;
    assign complete = accept & (ptr_q == PTR_MAX);

    always_comb begin
        ptr_adv = ptr_q;
        if (accept) begin
            ptr_adv = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
        end
        // A flush pads the open column with zeros from the post-write pointer upward.
        flush_fire = flush_req & st0_free & !complete & (ptr_adv != '0);
        ptr_d      = flush_fire ? '0 : ptr_adv;
        st0_wr_en  = '0;
        st0_wr_dat = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (accept && (PTR_W'(r) == ptr_q)) begin
                st0_wr_en[r] = 1'b1;
                st0_wr_dat[r*IO_DATA_WIDTH +: IO_DATA_WIDTH] = in_data;
            end else if (flush_fire && (PTR_W'(r) >= ptr_adv)) begin
                st0_wr_en[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            ods_col_stage #(
                .IO_DATA_WIDTH (IO_DATA_WIDTH),
                .NUM_ROWS      (NUM_ROWS)
            ) u_stage (
                .clk      (clk),
                .rst_in   (rst_in),
                .load_en  (1'b0),
                .load_dat ('0),
                .wr_en    (st0_wr_en),
                .wr_dat   (st0_wr_dat),
                .set_vld  (complete | flush_fire),
                .clr      (mv[0]),
                .col_dat  (col_dat[0]),
                .col_vld  (v[0])
            );
        end else begin : g_body
            ods_col_stage #(
                .IO_DATA_WIDTH (IO_DATA_WIDTH),
                .NUM_ROWS      (NUM_ROWS)
            ) u_stage (
                .clk      (clk),
                .rst_in   (rst_in),
                .load_en  (mv[k-1]),
                .load_dat (col_dat[k-1]),
                .wr_en    ('0),
                .wr_dat   ('0),
                .set_vld  (1'b0),
                .clr      (mv[k]),
                .col_dat  (col_dat[k]),
                .col_vld  (v[k])
            );
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + CNT_W'(v[k]);
        end
    end

    assign col_count = cnt;
    assign out_data  = col_dat[DEPTH-1];
    assign out_valid = v[DEPTH-1];

endmodule

// File: tb/tb_ods_array.sv
// Directed bench for ods_array: default 3x16 / depth-2 instance plus a 1-row, depth-1 instance.
module tb_ods_array;

    logic        clk;
    logic        rst_in;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  col_count;
    logic        flush_in;

    logic [7:0]  in_data1;
    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  out_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [0:0]  col_count1;
    logic        flush_in1;

    int errors = 0;
    int checks = 0;

    ods_array u_dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ODS_ARRAY_FLUSH_EN
        .flush_in  (flush_in),
`endif
        .col_count (col_count)
    );

    ods_array #(
        .IO_DATA_WIDTH (8),
        .NUM_ROWS      (1),
        .DEPTH         (1)
    ) u_dut1 (
        .clk       (clk),
        .rst_in    (rst_in),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
`ifdef ODS_ARRAY_FLUSH_EN
        .flush_in  (flush_in1),
`endif
        .col_count (col_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          w;
        int          ncol;
        logic        acc;
        logic [15:0] b;
        logic [47:0] exp_col;

        rst_in     = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        flush_in   = 1'b0;
        in_data1   = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        flush_in1  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_col_count", col_count, 0);
        chk("rst_out_data", out_data, 0);
        rst_in = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_in_ready1", in_ready1, 1);

        // Streaming with out_ready=1: words 1..6
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data = 16'd1; tick();
        in_data = 16'd2; tick();
        in_data = 16'd3; tick();
        chk("s_e3_out_valid", out_valid, 0);
        chk("s_e3_count", col_count, 1);
        in_data = 16'd4; tick();
        chk("s_e4_out_valid", out_valid, 1);
        chk("s_e4_out_data", out_data, 48'h0003_0002_0001);
        chk("s_e4_count", col_count, 1);
        in_data = 16'd5; tick();
        chk("s_e5_out_valid", out_valid, 0);
        chk("s_e5_count", col_count, 0);
        in_data = 16'd6; tick();
        chk("s_e6_count", col_count, 1);
        in_valid = 1'b0;
        tick();
        chk("s_e7_out_valid", out_valid, 1);
        chk("s_e7_out_data", out_data, 48'h0006_0005_0004);
        tick();
        chk("s_e8_out_valid", out_valid, 0);
        chk("s_e8_count", col_count, 0);

        // Backpressure: out_ready=0 fills both stages after six words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_data = 16'(i);
            tick();
        end
        chk("bp_in_ready", in_ready, 0);
        chk("bp_count", col_count, 2);
        chk("bp_out_data", out_data, 48'h0003_0002_0001);
        in_data = 16'd7;
        tick();
        tick();
        chk("bp_hold_in_ready", in_ready, 0);
        chk("bp_hold_out_valid", out_valid, 1);
        chk("bp_hold_out_data", out_data, 48'h0003_0002_0001);

        // Release: all 12 words must come out as four ordered columns
        out_ready = 1'b1;
        w    = 7;
        ncol = 0;
        for (int cyc = 0; cyc < 80 && ncol < 4; cyc++) begin
            in_valid = (w <= 12);
            in_data  = 16'(w);
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                b       = 16'(3 * ncol + 1);
                exp_col = {b + 16'd2, b + 16'd1, b};
                chk("bp_col", out_data, exp_col);
                ncol++;
            end
            tick();
            if (acc) w++;
        end
        in_valid = 1'b0;
        chk("bp_ncol", ncol, 4);
        chk("bp_words", w, 13);
        tick();
        chk("bp_empty_count", col_count, 0);

        // Stage 0 full and moving while a new word is accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 16'h61; tick();
        in_data = 16'h62; tick();
        in_data = 16'h63; tick();
        in_data = 16'h7;
        #1;
        chk("sim_in_ready", in_ready, 1);
        tick();
        chk("sim_count", col_count, 1);
        chk("sim_old_col", out_data, 48'h0063_0062_0061);
        in_data = 16'h8; tick();
        in_data = 16'h9; tick();
        chk("sim_full_count", col_count, 2);
        chk("sim_full_in_ready", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("sim_new_col", out_data, 48'h0009_0008_0007);
        chk("sim_new_count", col_count, 1);
        tick();
        chk("sim_drained", out_valid, 0);

        // Reset with one buffered column and a two-word partial column
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'(16'h21 + i);
            tick();
        end
        chk("mr_pre_count", col_count, 1);
        chk("mr_pre_out_data", out_data, 48'h0023_0022_0021);
        rst_in   = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mr_in_ready_low", in_ready, 0);
        tick();
        rst_in = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_count", col_count, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_in_ready", in_ready, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 16'h31; tick();
        in_data = 16'h32; tick();
        in_data = 16'h33; tick();
        in_valid = 1'b0;
        tick();
        chk("mr_clean_valid", out_valid, 1);
        chk("mr_clean_col", out_data, 48'h0033_0032_0031);
        tick();

`ifdef ODS_ARRAY_FLUSH_EN
        // Flush of a two-word column, flush with nothing open, flush alongside a write
        in_valid = 1'b1;
        in_data = 16'hA; tick();
        in_data = 16'hB; tick();
        in_valid = 1'b0;
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("fl_count", col_count, 1);
        tick();
        chk("fl_out_valid", out_valid, 1);
        chk("fl_out_data", out_data, 48'h0000_000B_000A);
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("fl_idle_count", col_count, 0);
        tick();
        chk("fl_idle_out_valid", out_valid, 0);
        in_valid = 1'b1;
        in_data = 16'hC; tick();
        in_data = 16'hD;
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        in_valid = 1'b0;
        chk("fl_wr_count", col_count, 1);
        tick();
        chk("fl_wr_out_data", out_data, 48'h0000_000D_000C);
        tick();
`endif

        // Single-row, single-stage instance: each word out on the next edge
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        in_data1 = 8'h11;
        #1;
        chk("r1_in_ready_a", in_ready1, 1);
        tick();
        chk("r1_valid_a", out_valid1, 1);
        chk("r1_data_a", out_data1, 8'h11);
        chk("r1_count_a", col_count1, 1);
        in_data1 = 8'h22;
        #1;
        chk("r1_in_ready_b", in_ready1, 1);
        tick();
        chk("r1_data_b", out_data1, 8'h22);
        in_data1 = 8'h33;
        #1;
        chk("r1_in_ready_c", in_ready1, 1);
        tick();
        chk("r1_data_c", out_data1, 8'h33);
        in_valid1 = 1'b0;
        tick();
        chk("r1_valid_end", out_valid1, 0);
        chk("r1_count_end", col_count1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
